// File: rtl/data_sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_responder_pkg
// Shared definitions for the data-RAM responder.
// Contents:
//   - service FSM state encoding
//   - byte-lane and word-width constants
//   - request-entry width helper, laid out as {wr, strobe, idx, wdata}
//   - byte-strobe merge helper used by the memory write path
// -----------------------------------------------------------------------------
package data_sram_responder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int LANES  = 4;
  localparam int WORD_W = 32;

  // Width of one queued request: wr + strobe + word index + write data.
  function automatic int entry_width(input int addr_w);
    return 1 + LANES + addr_w + WORD_W;
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_word,
                                                    input logic [WORD_W-1:0] new_word,
                                                    input logic [LANES-1:0]  strobe);
    logic [WORD_W-1:0] res;
    res = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (strobe[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// -----------------------------------------------------------------------------
// data_sram_responder_if
// Data-RAM request/response bundle between the memory stage (master) and the
// RAM responder (slave).
//   data_req/data_wr/data_size/data_addr/data_wdata : request, master -> slave
//   data_addr_ok                                     : accept, slave -> master
//   data_data_ok/data_rdata                          : completion, slave -> master
// -----------------------------------------------------------------------------
interface data_sram_responder_if;
  import data_sram_responder_pkg::*;

  logic              data_req;
  logic              data_wr;
  logic [LANES-1:0]  data_size;
  logic [WORD_W-1:0] data_addr;
  logic [WORD_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [WORD_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/data_sram_responder_fifo.sv
// -----------------------------------------------------------------------------
// data_req_fifo
// Synchronous FIFO holding accepted requests until the service FSM runs them.
// Ports:
//   clk, resetn      : clock, asynchronous active-low reset (empties the FIFO)
//   push, wr_data    : enqueue, ignored when full
//   pop              : dequeue head, ignored when empty
//   rd_data          : current head entry (valid when !empty)
//   full, empty      : occupancy flags
//   count            : number of stored entries
// -----------------------------------------------------------------------------
module data_req_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = store_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      store_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
// Data-side RAM responder for the 5-stage CPU. Requests are accepted into a
// small FIFO, then executed strictly in order by a serial FSM that spends
// LATENCY cycles per request against a byte-strobed 32-bit word memory.
// Ports:
//   clk     : clock
//   resetn  : asynchronous active-low reset
//   bus     : data-RAM bundle (slave side); data_addr_ok is combinational from
//             FIFO occupancy, data_data_ok/data_rdata are registered
// -----------------------------------------------------------------------------
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 2,
  parameter int LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  data_sram_responder_if.slave bus
);

  localparam int ENTRY_W = entry_width(ADDR_W);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WORDS   = 2 ** ADDR_W;
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LATENCY - 1);

  logic [WORD_W-1:0]  mem_r [WORDS];
  state_t             state_r;
  state_t             state_nxt_s;
  logic [LAT_W-1:0]   cnt_r;
  logic [LAT_W-1:0]   cnt_nxt_s;
  logic               exec_s;
  logic               addr_ok_s;
  logic               push_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   count_s;
  logic [ENTRY_W-1:0] entry_in_s;
  logic [ENTRY_W-1:0] head_s;
  logic               head_wr_s;
  logic [LANES-1:0]   head_strobe_s;
  logic [ADDR_W-1:0]  head_idx_s;
  logic [WORD_W-1:0]  head_wdata_s;
  logic               data_data_ok_r;
  logic [WORD_W-1:0]  data_rdata_r;

  // Byte-offset bits and bits above the word index are dropped, so upper
  // addresses alias onto the same word.
  assign entry_in_s    = {bus.data_wr, bus.data_size, bus.data_addr[ADDR_W+1:2], bus.data_wdata};
  assign head_wr_s     = head_s[ENTRY_W-1];
  assign head_strobe_s = head_s[ENTRY_W-2 -: LANES];
  assign head_idx_s    = head_s[WORD_W +: ADDR_W];
  assign head_wdata_s  = head_s[WORD_W-1:0];

  // No same-cycle pop bypass: a full FIFO refuses until the edge after a pop.
  assign addr_ok_s        = resetn & ~full_s;
  assign push_s           = bus.data_req & addr_ok_s;
  assign bus.data_addr_ok = addr_ok_s;
  assign bus.data_data_ok = data_data_ok_r;
  assign bus.data_rdata   = data_rdata_r;

  data_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_s),
    .wr_data (entry_in_s),
    .pop     (exec_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s)
  );

  // FSM state and latency counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= LAT_W'(0);
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; after executing, stay busy if anything remains queued
  // once this edge's pop and any simultaneous push have both landed.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = LAT_RELOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_WAIT: begin
        if (cnt_r != LAT_W'(0)) begin
          cnt_nxt_s = cnt_r - LAT_W'(1);
        end else if ((count_s > CNT_W'(1)) || push_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = LAT_RELOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = LAT_W'(0);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = LAT_W'(0);
      end
    endcase
  end

  // Execute strobe: head entry is serviced and popped on this edge.
  always_comb begin
    exec_s = 1'b0;
    if ((state_r == ST_WAIT) && (cnt_r == LAT_W'(0))) begin
      exec_s = 1'b1;
    end else begin
      exec_s = 1'b0;
    end
  end

  // Registered completion pulse and read data; writes leave rdata untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_data_ok_r <= 1'b0;
      data_rdata_r   <= {WORD_W{1'b0}};
    end else begin
      data_data_ok_r <= exec_s;
      if (exec_s && !head_wr_s) begin
        data_rdata_r <= mem_r[head_idx_s];
      end
    end
  end

  // Byte-strobed word memory; intentionally not reset.
  always_ff @(posedge clk) begin
    if (exec_s && head_wr_s) begin
      mem_r[head_idx_s] <= merge_bytes(mem_r[head_idx_s], head_wdata_s, head_strobe_s);
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// -----------------------------------------------------------------------------
// tb_data_sram_responder
// Directed bench for data_sram_responder (default parameters). Each accepted
// request pushes its expected completion edge and read data into a queue; a
// negedge monitor pops and compares when data_data_ok is seen.
// -----------------------------------------------------------------------------
module tb_data_sram_responder;

  localparam int LAT = 2;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          done_edge;
  } sb_t;

  logic clk;
  logic resetn;
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   prev_done = -100;
  sb_t  sb[$];

  data_sram_responder_if bus ();

  data_sram_responder #(
    .ADDR_W     (10),
    .FIFO_DEPTH (2),
    .LATENCY    (LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Completion monitor, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (resetn === 1'b1 && bus.data_data_ok === 1'b1) begin
      check("ok_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_edge", 32'(cyc), 32'(e.done_edge));
        if (e.is_read) check("rdata", bus.data_rdata, e.rdata);
      end
    end
  end

  // Drive one request (called at a negedge), wait for acceptance, record
  // the expected completion; leaves data_req high on return.
  task automatic issue(input logic wr, input logic [3:0] strb, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, output int acc);
    int n;
    int done;
    n = 0;
    bus.data_req   = 1'b1;
    bus.data_wr    = wr;
    bus.data_size  = strb;
    bus.data_addr  = addr;
    bus.data_wdata = wdata;
    while (bus.data_addr_ok !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 32'(n < 20), 32'd1);
    acc = cyc + 1;
    if (acc <= prev_done) done = prev_done + LAT;
    else                  done = acc + 1 + LAT;
    prev_done = done;
    sb.push_back('{is_read: !wr, rdata: exp, done_edge: done});
    @(negedge clk);
  endtask

  task automatic idle();
    bus.data_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.data_req = 1'b0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int a1, a2, a3;
    resetn         = 1'b0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 4'b0000;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;

    // Reset state.
    @(negedge clk);
    #1;
    check("rst_addr_ok", 32'(bus.data_addr_ok), 32'd0);
    check("rst_data_ok", 32'(bus.data_data_ok), 32'd0);
    check("rst_rdata", bus.data_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post_rst_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    @(negedge clk);

    // Full-word write then read, with idle gaps.
    issue(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0, a1);
    idle();
    issue(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADBEEF, a1);
    idle();
    drain();

    // Byte-strobed writes, including an all-zero strobe, read back in order.
    issue(1'b1, 4'b0001, 32'h10, 32'h11223344, 32'h0, a1);
    issue(1'b0, 4'b1111, 32'h10, 32'h0, 32'hDEADBE44, a1);
    issue(1'b1, 4'b1100, 32'h10, 32'hAABB0000, 32'h0, a1);
    issue(1'b0, 4'b0000, 32'h10, 32'h0, 32'hAABBBE44, a1);
    issue(1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h0, a1);
    issue(1'b0, 4'b1111, 32'h10, 32'h0, 32'hAABBBE44, a1);
    drain();

    // Held request stream against a two-deep FIFO.
    issue(1'b1, 4'b1111, 32'h30, 32'h01010101, 32'h0, a1);
    issue(1'b1, 4'b1111, 32'h34, 32'h02020202, 32'h0, a2);
    issue(1'b0, 4'b1111, 32'h30, 32'h0, 32'h01010101, a3);
    check("full_acc2", 32'(a2 - a1), 32'd1);
    check("full_acc3", 32'(a3 - a1), 32'd4);
    drain();

    // Address aliasing and low-bit drop.
    issue(1'b1, 4'b1111, 32'h10000010, 32'h5A5A5A5A, 32'h0, a1);
    idle();
    issue(1'b0, 4'b1111, 32'h00000013, 32'h0, 32'h5A5A5A5A, a1);
    drain();

    // Write then read of the same word on consecutive edges.
    issue(1'b1, 4'b1111, 32'h50, 32'hCAFEF00D, 32'h0, a1);
    issue(1'b0, 4'b1111, 32'h50, 32'h0, 32'hCAFEF00D, a2);
    check("wr_rd_acc", 32'(a2 - a1), 32'd1);
    drain();

    // Reset one cycle after an accept abandons the write.
    issue(1'b1, 4'b1111, 32'h60, 32'h11111111, 32'h0, a1);
    drain();
    issue(1'b1, 4'b1111, 32'h60, 32'h22222222, 32'h0, a1);
    bus.data_req = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    sb.delete();
    prev_done = -100;
    #1;
    check("mid_rst_addr_ok", 32'(bus.data_addr_ok), 32'd0);
    check("mid_rst_data_ok", 32'(bus.data_data_ok), 32'd0);
    check("mid_rst_rdata", bus.data_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("rel_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_ok", 32'(bus.data_data_ok), 32'd0);
    end
    check("rel_rdata", bus.data_rdata, 32'h0);
    issue(1'b0, 4'b1111, 32'h60, 32'h0, 32'h11111111, a1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
